// File: rtl/divider_arbiter.sv
// Round-robin arbiter that shares one sequential 16-bit unsigned divider
// among N requesters. It owns the divider's reset, start and operand lines,
// answers divide-by-zero itself without touching the divider, and aborts an
// operation whose divider never reports completion within TIMEOUT cycles.
module divider_arbiter #(
    parameter int N       = 4,
    parameter int TIMEOUT = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic [16*N-1:0] a_in,
    input  logic [16*N-1:0] b_in,
    output logic [N-1:0]    gnt,
    output logic [N-1:0]    rsp_valid,
    output logic [15:0]     rsp_y,
    output logic [15:0]     rsp_rem,
    output logic            rsp_div0,
    output logic            rsp_err,
    output logic            busy,
    output logic            div_rst,
    output logic            div_start,
    output logic [15:0]     div_a,
    output logic [15:0]     div_b,
    input  logic            div_done,
    input  logic [15:0]     div_y,
    input  logic [15:0]     div_rem
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_START = 3'd2,
        ST_WAIT  = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

    state_t          state_q;
    logic [IW-1:0]   ptr_q;
    logic [IW-1:0]   owner_q;
    logic [CW-1:0]   cnt_q;
    logic [N-1:0]    gnt_q;
    logic [N-1:0]    rsp_valid_q;
    logic [15:0]     rsp_y_q;
    logic [15:0]     rsp_rem_q;
    logic            rsp_div0_q;
    logic            rsp_err_q;
    logic            busy_q;
    logic            div_rst_q;
    logic            div_start_q;
    logic [15:0]     div_a_q;
    logic [15:0]     div_b_q;

    logic            sel_found_s;
    logic [IW-1:0]   sel_idx_s;
    logic [IW:0]     cand_s;
    logic [15:0]     sel_a_s;
    logic [15:0]     sel_b_s;

    // One-hot vector with only bit idx set.
    function automatic logic [N-1:0] onehot(input logic [IW-1:0] idx);
        onehot = {{(N-1){1'b0}}, 1'b1} << idx;
    endfunction

    // First requesting index at or above the pointer, wrapping past N-1.
    always_comb begin
        sel_found_s = 1'b0;
        sel_idx_s   = '0;
        cand_s      = '0;
        for (int k = 0; k < N; k++) begin
            cand_s = {1'b0, ptr_q} + (IW+1)'(k);
            cand_s = (cand_s >= (IW+1)'(N)) ? cand_s - (IW+1)'(N) : cand_s;
            if (!sel_found_s && req[cand_s[IW-1:0]]) begin
                sel_found_s = 1'b1;
                sel_idx_s   = cand_s[IW-1:0];
            end else begin
                sel_found_s = sel_found_s;
            end
        end
    end

    // Operand mux for the selected requester.
    always_comb begin
        sel_a_s = 16'h0000;
        sel_b_s = 16'h0000;
        for (int i = 0; i < N; i++) begin
            if (sel_idx_s == IW'(i)) begin
                sel_a_s = a_in[16*i +: 16];
                sel_b_s = b_in[16*i +: 16];
            end else begin
                sel_a_s = sel_a_s;
                sel_b_s = sel_b_s;
            end
        end
    end

    // Arbitration FSM; every output is a register updated here.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            owner_q     <= '0;
            cnt_q       <= '0;
            gnt_q       <= '0;
            rsp_valid_q <= '0;
            rsp_y_q     <= 16'h0000;
            rsp_rem_q   <= 16'h0000;
            rsp_div0_q  <= 1'b0;
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b0;
            div_rst_q   <= 1'b1;
            div_start_q <= 1'b0;
            div_a_q     <= 16'h0000;
            div_b_q     <= 16'h0000;
        end else begin
            // Strobes are single-cycle unless a state re-asserts them below.
            gnt_q       <= '0;
            rsp_valid_q <= '0;
            div_rst_q   <= 1'b0;
            div_start_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (sel_found_s) begin
                        owner_q <= sel_idx_s;
                        gnt_q   <= onehot(sel_idx_s);
                        busy_q  <= 1'b1;
                        if (sel_b_s != 16'h0000) begin
                            state_q   <= ST_CLEAR;
                            div_rst_q <= 1'b1;
                            div_a_q   <= sel_a_s;
                            div_b_q   <= sel_b_s;
                        end else begin
                            // Divide-by-zero is answered without the divider.
                            state_q     <= ST_RESP;
                            rsp_valid_q <= onehot(sel_idx_s);
                            rsp_y_q     <= 16'hFFFF;
                            rsp_rem_q   <= sel_a_s;
                            rsp_div0_q  <= 1'b1;
                            rsp_err_q   <= 1'b0;
                        end
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                ST_CLEAR: begin
                    state_q     <= ST_START;
                    div_start_q <= 1'b1;
                end
                ST_START: begin
                    state_q <= ST_WAIT;
                    cnt_q   <= '0;
                end
                ST_WAIT: begin
                    // Completion takes priority over a coincident timeout.
                    if (div_done) begin
                        state_q     <= ST_RESP;
                        rsp_valid_q <= onehot(owner_q);
                        rsp_y_q     <= div_y;
                        rsp_rem_q   <= div_rem;
                        rsp_div0_q  <= 1'b0;
                        rsp_err_q   <= 1'b0;
                    end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                        state_q     <= ST_RESP;
                        rsp_valid_q <= onehot(owner_q);
                        rsp_y_q     <= 16'h0000;
                        rsp_rem_q   <= 16'h0000;
                        rsp_div0_q  <= 1'b0;
                        rsp_err_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    if (owner_q == IW'(N - 1)) begin
                        ptr_q <= '0;
                    end else begin
                        ptr_q <= owner_q + IW'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign gnt       = gnt_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_y     = rsp_y_q;
    assign rsp_rem   = rsp_rem_q;
    assign rsp_div0  = rsp_div0_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = busy_q;
    assign div_rst   = div_rst_q;
    assign div_start = div_start_q;
    assign div_a     = div_a_q;
    assign div_b     = div_b_q;

endmodule

// File: tb/tb_divider_arbiter.sv
// Testbench for divider_arbiter: behavioural divider model with a
// programmable latency (or never completing), reference values computed
// from plain arithmetic and a round-robin rule evaluated per grant.
module tb_divider_arbiter;

    localparam int N       = 4;
    localparam int TIMEOUT = 64;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic [16*N-1:0] a_in;
    logic [16*N-1:0] b_in;
    logic [N-1:0]    gnt;
    logic [N-1:0]    rsp_valid;
    logic [15:0]     rsp_y;
    logic [15:0]     rsp_rem;
    logic            rsp_div0;
    logic            rsp_err;
    logic            busy;
    logic            div_rst;
    logic            div_start;
    logic [15:0]     div_a;
    logic [15:0]     div_b;
    logic            div_done = 1'b0;
    logic [15:0]     div_y    = 16'h0000;
    logic [15:0]     div_rem  = 16'h0000;

    int checks   = 0;
    int failures = 0;

    // divider model state
    int          m_lat     = 1;
    int          m_cnt     = 0;
    bit          stub_mode = 1'b0;
    logic [15:0] m_a       = 16'h0000;
    logic [15:0] m_b       = 16'h0001;

    divider_arbiter #(.N(N), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in),
        .gnt(gnt), .rsp_valid(rsp_valid), .rsp_y(rsp_y), .rsp_rem(rsp_rem),
        .rsp_div0(rsp_div0), .rsp_err(rsp_err), .busy(busy),
        .div_rst(div_rst), .div_start(div_start), .div_a(div_a), .div_b(div_b),
        .div_done(div_done), .div_y(div_y), .div_rem(div_rem)
    );

    always #5 clk = ~clk;

    // Sequential divider model: done pulses m_lat cycles after start.
    always @(posedge clk) begin
        if (div_rst) begin
            div_done <= 1'b0;
            m_cnt    <= 0;
        end else if (div_start) begin
            div_done <= 1'b0;
            m_a      <= div_a;
            m_b      <= div_b;
            m_cnt    <= m_lat;
        end else if (m_cnt == 1 && !stub_mode) begin
            div_done <= 1'b1;
            div_y    <= m_a / m_b;
            div_rem  <= m_a % m_b;
            m_cnt    <= 0;
        end else begin
            div_done <= 1'b0;
            if (m_cnt > 1) m_cnt <= m_cnt - 1;
        end
    end

    function automatic int rr_pick(input logic [N-1:0] m, input int p);
        for (int k = 0; k < N; k++) begin
            if (m[(p + k) % N]) return (p + k) % N;
        end
        return 0;
    endfunction

    // One single-requester transaction; returns observations, compares nothing.
    task automatic do_txn(input int idx, input logic [15:0] a, input logic [15:0] b, input int lat,
                          output logic [N-1:0] g, output logic [N-1:0] rv,
                          output logic [15:0] y, output logic [15:0] rem,
                          output logic d0, output logic er, output int n_rst,
                          output int n_start, output bit stable, output int lc);
        bit seen;
        g = '0; rv = '0; y = 16'h0; rem = 16'h0; d0 = 1'b0; er = 1'b0;
        n_rst = 0; n_start = 0; stable = 1'b1; lc = -1;
        m_lat = lat;
        for (int i = 0; i < N; i++) begin
            a_in[16*i +: 16] = 16'($urandom);
            b_in[16*i +: 16] = 16'($urandom);
        end
        a_in[16*idx +: 16] = a;
        b_in[16*idx +: 16] = b;
        req = '0;
        req[idx] = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (|gnt) seen = 1'b1;
        end
        if (!seen) begin
            req = '0;
            return;
        end
        g = gnt;
        req = '0;
        for (int i = 0; i < N; i++) begin
            a_in[16*i +: 16] = 16'($urandom);
            b_in[16*i +: 16] = 16'($urandom);
        end
        seen = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin
            if (c > 0) @(negedge clk);
            if (div_rst) n_rst++;
            if (div_start) n_start++;
            if (b != 16'd0 && (div_a !== a || div_b !== b)) stable = 1'b0;
            if (|rsp_valid) begin
                seen = 1'b1;
                rv = rsp_valid; y = rsp_y; rem = rsp_rem; d0 = rsp_div0; er = rsp_err; lc = c;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; req = '0; a_in = '0; b_in = '0;
        repeat (3) @(negedge clk);
        checks++; if (gnt !== 4'b0000 || rsp_valid !== 4'b0000) begin failures++; $display("FAIL reset_strobes: gnt=%b rsp_valid=%b expected 0000", gnt, rsp_valid); end
        checks++; if ({rsp_y, rsp_rem, rsp_div0, rsp_err} !== 34'd0) begin failures++; $display("FAIL reset_rsp: y=%h rem=%h div0=%b err=%b expected 0", rsp_y, rsp_rem, rsp_div0, rsp_err); end
        checks++; if (busy !== 1'b0 || div_start !== 1'b0) begin failures++; $display("FAIL reset_busy_start: busy=%b div_start=%b expected 0", busy, div_start); end
        checks++; if (div_a !== 16'd0 || div_b !== 16'd0) begin failures++; $display("FAIL reset_operands: div_a=%h div_b=%h expected 0", div_a, div_b); end
        checks++; if (div_rst !== 1'b1) begin failures++; $display("FAIL reset_div_rst: got %b expected 1", div_rst); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (div_rst !== 1'b0) begin failures++; $display("FAIL release_div_rst: got %b expected 0", div_rst); end
        checks++; if (busy !== 1'b0 || gnt !== 4'b0000) begin failures++; $display("FAIL release_idle: busy=%b gnt=%b expected 0", busy, gnt); end
    endtask

    task automatic test_basic();
        int          idxs[3] = '{0, 2, 1};
        logic [15:0] as_t[3] = '{16'd110, 16'd32200, 16'd1234};
        logic [15:0] bs_t[3] = '{16'd25, 16'd37, 16'd56};
        logic [15:0] ys_t[3] = '{16'd4, 16'd870, 16'd22};
        logic [15:0] rs_t[3] = '{16'd10, 16'd10, 16'd2};
        logic [N-1:0] g, rv, ex;
        logic [15:0] y, rem;
        logic d0, er;
        int n_rst, n_start, lc, lat;
        bit stable;
        for (int t = 0; t < 3; t++) begin
            lat = $urandom_range(1, 20);
            do_txn(idxs[t], as_t[t], bs_t[t], lat, g, rv, y, rem, d0, er, n_rst, n_start, stable, lc);
            ex = '0; ex[idxs[t]] = 1'b1;
            checks++; if (g !== ex) begin failures++; $display("FAIL basic_gnt[%0d]: got %b expected %b", t, g, ex); end
            checks++; if (rv !== ex) begin failures++; $display("FAIL basic_rsp_valid[%0d]: got %b expected %b", t, rv, ex); end
            checks++; if (y !== ys_t[t] || rem !== rs_t[t]) begin failures++; $display("FAIL basic_result[%0d]: got %0d r%0d expected %0d r%0d", t, y, rem, ys_t[t], rs_t[t]); end
            checks++; if (d0 !== 1'b0 || er !== 1'b0) begin failures++; $display("FAIL basic_flags[%0d]: div0=%b err=%b expected 0 0", t, d0, er); end
            checks++; if (n_rst != 1 || n_start != 1) begin failures++; $display("FAIL basic_pulses[%0d]: div_rst=%0d div_start=%0d expected 1 1", t, n_rst, n_start); end
            checks++; if (!stable) begin failures++; $display("FAIL basic_operands_stable[%0d]: got unstable expected stable", t); end
            checks++; if (lc != lat + 3) begin failures++; $display("FAIL basic_latency[%0d]: got %0d expected %0d", t, lc, lat + 3); end
            @(negedge clk);
            checks++; if (rsp_valid !== 4'b0000 || rsp_y !== ys_t[t] || rsp_rem !== rs_t[t] || busy !== 1'b0) begin failures++; $display("FAIL basic_hold[%0d]: valid=%b y=%0d rem=%0d busy=%b expected 0000 %0d %0d 0", t, rsp_valid, rsp_y, rsp_rem, busy, ys_t[t], rs_t[t]); end
        end
    endtask

    task automatic test_div0();
        logic [N-1:0] g, rv;
        logic [15:0] y, rem;
        logic d0, er;
        int n_rst, n_start, lc;
        bit stable, quiet;
        do_txn(3, 16'd500, 16'd0, 5, g, rv, y, rem, d0, er, n_rst, n_start, stable, lc);
        checks++; if (g !== 4'b1000 || rv !== 4'b1000) begin failures++; $display("FAIL div0_strobes: gnt=%b rsp_valid=%b expected 1000 1000", g, rv); end
        checks++; if (lc != 0) begin failures++; $display("FAIL div0_latency: got %0d expected 0", lc); end
        checks++; if (y !== 16'hFFFF || rem !== 16'd500) begin failures++; $display("FAIL div0_result: got %h r%0d expected ffff r500", y, rem); end
        checks++; if (d0 !== 1'b1 || er !== 1'b0) begin failures++; $display("FAIL div0_flags: div0=%b err=%b expected 1 0", d0, er); end
        quiet = (n_rst == 0 && n_start == 0);
        repeat (3) begin
            @(negedge clk);
            if (div_rst || div_start) quiet = 1'b0;
        end
        checks++; if (!quiet) begin failures++; $display("FAIL div0_no_divider: got divider pulse expected none"); end
    endtask

    task automatic test_random();
        logic [N-1:0] g, rv, ex;
        logic [15:0] y, rem, a, b, ey, erem;
        logic d0, er;
        int n_rst, n_start, lc, lat, idx, elat;
        bit stable;
        for (int t = 0; t < 12; t++) begin
            idx = $urandom_range(0, N - 1);
            a   = 16'($urandom);
            if ($urandom_range(0, 4) == 0) b = 16'd0;
            else if ($urandom_range(0, 1) == 1) b = 16'($urandom_range(1, 15));
            else b = 16'($urandom);
            lat = $urandom_range(1, 25);
            do_txn(idx, a, b, lat, g, rv, y, rem, d0, er, n_rst, n_start, stable, lc);
            ex = '0; ex[idx] = 1'b1;
            ey   = (b == 16'd0) ? 16'hFFFF : a / b;
            erem = (b == 16'd0) ? a : a % b;
            elat = (b == 16'd0) ? 0 : lat + 3;
            checks++; if (g !== ex || rv !== ex) begin failures++; $display("FAIL rand_strobes[%0d]: gnt=%b rsp_valid=%b expected %b", t, g, rv, ex); end
            checks++; if (y !== ey || rem !== erem) begin failures++; $display("FAIL rand_result[%0d]: %0d/%0d got %0d r%0d expected %0d r%0d", t, a, b, y, rem, ey, erem); end
            checks++; if (d0 !== (b == 16'd0) || er !== 1'b0) begin failures++; $display("FAIL rand_flags[%0d]: div0=%b err=%b expected %b 0", t, d0, er, (b == 16'd0)); end
            checks++; if (lc != elat) begin failures++; $display("FAIL rand_latency[%0d]: got %0d expected %0d", t, lc, elat); end
        end
    endtask

    task automatic test_timeout();
        logic [N-1:0] g, rv;
        logic [15:0] y, rem;
        logic d0, er;
        int n_rst, n_start, lc;
        bit stable, quiet;
        stub_mode = 1'b1;
        do_txn(2, 16'd1000, 16'd7, 5, g, rv, y, rem, d0, er, n_rst, n_start, stable, lc);
        checks++; if (g !== 4'b0100 || rv !== 4'b0100) begin failures++; $display("FAIL tmo_strobes: gnt=%b rsp_valid=%b expected 0100", g, rv); end
        checks++; if (lc != TIMEOUT + 2) begin failures++; $display("FAIL tmo_latency: got %0d expected %0d", lc, TIMEOUT + 2); end
        checks++; if (er !== 1'b1 || d0 !== 1'b0 || y !== 16'd0 || rem !== 16'd0) begin failures++; $display("FAIL tmo_result: err=%b div0=%b y=%0d rem=%0d expected 1 0 0 0", er, d0, y, rem); end
        // releasing the stub lets a stale done pulse arrive while idle
        stub_mode = 1'b0;
        quiet = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (|rsp_valid || busy) quiet = 1'b0;
        end
        checks++; if (!quiet) begin failures++; $display("FAIL tmo_stray_done: got activity expected idle"); end
        do_txn(0, 16'd110, 16'd25, 6, g, rv, y, rem, d0, er, n_rst, n_start, stable, lc);
        checks++; if (rv !== 4'b0001 || y !== 16'd4 || rem !== 16'd10 || er !== 1'b0) begin failures++; $display("FAIL tmo_recover: valid=%b y=%0d rem=%0d err=%b expected 0001 4 10 0", rv, y, rem, er); end
    endtask

    task automatic test_reset_mid();
        logic [N-1:0] g, rv;
        logic [15:0] y, rem;
        logic d0, er;
        int n_rst, n_start, lc;
        bit stable, seen, ok;
        do_txn(1, 16'd300, 16'd7, 4, g, rv, y, rem, d0, er, n_rst, n_start, stable, lc);
        checks++; if (y !== 16'd42 || rem !== 16'd6) begin failures++; $display("FAIL rmid_pre: got %0d r%0d expected 42 r6", y, rem); end
        m_lat = 40;
        a_in[32 +: 16] = 16'd9999;
        b_in[32 +: 16] = 16'd3;
        req = 4'b0100;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (|gnt) seen = 1'b1;
        end
        checks++; if (gnt !== 4'b0100) begin failures++; $display("FAIL rmid_gnt: got %b expected 0100", gnt); end
        req = '0;
        repeat (6) @(negedge clk);
        checks++; if (busy !== 1'b1 || div_a !== 16'd9999) begin failures++; $display("FAIL rmid_in_wait: busy=%b div_a=%0d expected 1 9999", busy, div_a); end
        rst = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || div_rst !== 1'b1) begin failures++; $display("FAIL rmid_busy_rst: busy=%b div_rst=%b expected 0 1", busy, div_rst); end
        checks++; if (gnt !== 4'b0000 || rsp_valid !== 4'b0000 || div_start !== 1'b0) begin failures++; $display("FAIL rmid_strobes: gnt=%b valid=%b start=%b expected 0", gnt, rsp_valid, div_start); end
        checks++; if ({div_a, div_b, rsp_y, rsp_rem, rsp_div0, rsp_err} !== 66'd0) begin failures++; $display("FAIL rmid_data: a=%h b=%h y=%h rem=%h d0=%b err=%b expected 0", div_a, div_b, rsp_y, rsp_rem, rsp_div0, rsp_err); end
        ok = 1'b1;
        repeat (2) begin
            @(negedge clk);
            if (|rsp_valid) ok = 1'b0;
        end
        rst = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (|rsp_valid || |gnt || busy) ok = 1'b0;
        end
        checks++; if (!ok) begin failures++; $display("FAIL rmid_no_response: got activity expected none"); end
        a_in[16 +: 16] = 16'd5000; b_in[16 +: 16] = 16'd9;
        a_in[32 +: 16] = 16'd777;  b_in[32 +: 16] = 16'd5;
        m_lat = 3;
        req = 4'b0110;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (|gnt) seen = 1'b1;
        end
        checks++; if (gnt !== 4'b0010) begin failures++; $display("FAIL rmid_ptr_reset: got %b expected 0010", gnt); end
        req = '0;
        seen = 1'b0;
        for (int c = 0; c < 100 && !seen; c++) begin
            @(negedge clk);
            if (|rsp_valid) seen = 1'b1;
        end
        checks++; if (rsp_valid !== 4'b0010 || rsp_y !== 16'd555 || rsp_rem !== 16'd5) begin failures++; $display("FAIL rmid_after: valid=%b y=%0d rem=%0d expected 0010 555 5", rsp_valid, rsp_y, rsp_rem); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_round_robin();
        logic [15:0]  av[N];
        logic [15:0]  bv[N];
        logic [15:0]  ea, eb, ey, erem;
        logic [N-1:0] mask, ex;
        int ptr, own;
        bit seen;
        rst = 1'b0;
        mask = '1;
        req = mask;
        for (int i = 0; i < N; i++) begin
            av[i] = 16'(1000 * (i + 1) + $urandom_range(0, 999));
            bv[i] = 16'($urandom_range(1, 300));
            a_in[16*i +: 16] = av[i];
            b_in[16*i +: 16] = bv[i];
        end
        m_lat = $urandom_range(1, 20);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        ptr = 0;
        for (int t = 0; t < 13; t++) begin
            own = rr_pick(mask, ptr);
            ex = '0; ex[own] = 1'b1;
            ea = av[own]; eb = bv[own];
            seen = 1'b0;
            for (int c = 0; c < 20 && !seen; c++) begin
                @(negedge clk);
                if (|gnt) seen = 1'b1;
            end
            checks++; if (gnt !== ex) begin failures++; $display("FAIL rr_grant[%0d]: got %b expected %b mask=%b", t, gnt, ex, mask); end
            if (!seen) break;
            m_lat = $urandom_range(1, 20);
            av[own] = 16'($urandom);
            bv[own] = (t >= 5 && $urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1, 65535));
            a_in[16*own +: 16] = av[own];
            b_in[16*own +: 16] = bv[own];
            seen = (|rsp_valid);
            for (int c = 0; c < 100 && !seen; c++) begin
                @(negedge clk);
                if (|rsp_valid) seen = 1'b1;
            end
            ey   = (eb == 16'd0) ? 16'hFFFF : ea / eb;
            erem = (eb == 16'd0) ? ea : ea % eb;
            checks++; if (rsp_valid !== ex) begin failures++; $display("FAIL rr_rsp_valid[%0d]: got %b expected %b", t, rsp_valid, ex); end
            checks++; if (rsp_y !== ey || rsp_rem !== erem || rsp_div0 !== (eb == 16'd0)) begin failures++; $display("FAIL rr_result[%0d]: got %0d r%0d d0=%b expected %0d r%0d d0=%b", t, rsp_y, rsp_rem, rsp_div0, ey, erem, (eb == 16'd0)); end
            ptr = (own + 1) % N;
            if (t >= 4) begin
                mask = N'($urandom_range(1, (1 << N) - 1));
                req = mask;
            end
        end
        req = '0;
        repeat (3) @(negedge clk);
    endtask

    // Hard time limit so the run always terminates.
    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    // Test sequence.
    initial begin
        test_reset();
        test_basic();
        test_div0();
        test_random();
        test_timeout();
        test_reset_mid();
        test_round_robin();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/divider_arbiter.md
Name: divider_arbiter

Overview:
- Shares one divider_seq instance (16-bit sequential unsigned divider: start/done, a, b, y, remainder, active-high rst) among N requesters.
- Round-robin arbitration; owns the divider's reset, start and operand lines.
- Short-circuits divide-by-zero and aborts on divider timeout.
- Responses are routed back to the granted requester; results are also suitable for driving led_encoder.

Parameters:
- N, 4, number of requesters (2..8).
- TIMEOUT, 64, maximum WAIT cycles before abort (≥ 20).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req  in  N  per-requester request level.
- a_in  in  16*N  dividend, requester i at bits [16i+15:16i].
- b_in  in  16*N  divisor, same packing.
- gnt  out  N  one-hot grant, one-cycle pulse.
- rsp_valid  out  N  one-hot response strobe, one-cycle pulse.
- rsp_y  out  16  quotient.
- rsp_rem  out  16  remainder.
- rsp_div0  out  1  divisor was zero.
- rsp_err  out  1  divider timeout.
- busy  out  1  high whenever state ≠ IDLE.
- div_rst  out  1  active-high reset to divider.
- div_start  out  1  divider start pulse.
- div_a  out  16  divider dividend.
- div_b  out  16  divider divisor.
- div_done  in  1  divider completion.
- div_y  in  16  divider quotient.
- div_rem  in  16  divider remainder.

Behaviour:
- All outputs are registered.
- Reset (rst=0, async) values:
  - state=IDLE, RR pointer=0.
  - gnt, rsp_valid, rsp_y, rsp_rem, rsp_div0, rsp_err, busy, div_start, div_a, div_b = 0.
  - div_rst = 1; it drops to 0 on the first clock after rst is released.
- States: IDLE, CLEAR, START, WAIT, RESP.
- IDLE:
  - If any req bit is set, select the first set bit searching from the pointer upward with wrap.
  - Latch owner index, a and b.
  - Pulse gnt[owner] for the next cycle.
  - If b≠0, go to CLEAR; if b=0, go to RESP with div0.
  - If no req bit is set, stay in IDLE.
- CLEAR (1 cycle): div_rst=1; div_a/div_b are driven with the latched operands.
- START (1 cycle): div_start=1.
- WAIT:
  - div_a/div_b are held stable.
  - Cycle counter clears on entry.
  - If div_done=1: capture div_y/div_rem, go to RESP.
  - If the counter reaches TIMEOUT-1 without div_done: go to RESP with rsp_err=1, rsp_y=0, rsp_rem=0.
  - div_done and timeout in the same cycle: done wins.
- RESP (1 cycle):
  - rsp_valid[owner]=1.
  - rsp_y/rsp_rem/rsp_div0/rsp_err are valid this cycle and hold until the next RESP.
  - Pointer = (owner+1) mod N.
  - Go to IDLE.
- div0 response: rsp_y=16'hFFFF, rsp_rem=a, rsp_div0=1; div_rst and div_start are never asserted.
- Latency:
  - Normal: IDLE(req seen) → CLEAR → START → WAIT(k cycles, k≥1) → RESP. rsp_valid is 3+k cycles after the req-sampling edge.
  - div0: rsp_valid 1 cycle after sampling.
- div_done is ignored outside WAIT.
- Operands are latched at grant; the requester may change a_in/b_in or drop req after gnt.
- A requester that keeps req high after its rsp_valid is re-arbitrated as a new request.
- A req deasserted before grant is never served; there is no memory of requests.
- Only one operation is in flight; other requesters wait without loss of ordering fairness.
- Reset mid-operation:
  - Everything returns to reset values immediately.
  - No rsp_valid is emitted for the aborted operation.
  - div_rst=1 forces the divider idle.

Test Plan:
- N=4, real divider_seq, req[0] only, a=110, b=25 → gnt[0] pulse; div_rst then div_start pulses; rsp_valid[0] with rsp_y=4, rsp_rem=10, rsp_div0=0, rsp_err=0.
- req[2], a=32200, b=37 → rsp_y=870, rsp_rem=10; then req[1], a=1234, b=56 → rsp_y=22, rsp_rem=2; div_a/div_b stable throughout each WAIT.
- req=4'b1111 held continuously from reset, each requester with distinct operands → grant order 0,1,2,3,0; every response carries the correct owner's result.
- req[3], a=500, b=0 → rsp_valid[3] one cycle after sampling; rsp_y=16'hFFFF, rsp_rem=500, rsp_div0=1; div_start and div_rst never pulse.
- Stub divider with div_done tied 0, TIMEOUT=64 → exactly 64 WAIT cycles, then rsp_err=1, rsp_y=0, rsp_rem=0; the next request (110/25 with the real divider) succeeds.
- rst=0 asserted mid-WAIT → busy=0, div_rst=1, and all other outputs 0 within the same cycle; no rsp_valid; after release, req=4'b0110 is granted to 1 first (pointer=0).
